mem_avalon_bridge_mp: RTL and testbench
=======================================

// Module: mem_avalon_bridge_mp
// PURPOSE
// - Parametrised successor to the single-port SDRAM bridge: N CPU/DMA memory ports share one Avalon-MM slave (SDRAM core).
// - Each XLEN-wide access is split into XLEN/AV_WIDTH narrow beats, with pipelined reads and round-robin arbitration.
// - Write beats whose byte enables are all zero are skipped.
// - Sits between the MCU/loader memory ports and the SDRAM core, in the clk_100MHz domain.
// PARAMETERS
// - NUM_PORTS   2    number of requesting ports (1..8)
// - XLEN        32   requester data width
// - AV_WIDTH    16   Avalon data width; XLEN/AV_WIDTH = RATIO, a power of 2 (1..8)
// - ADDR_BITS   21   requester word-address width (XLEN-word units)
// PORTS
// - clk                 in   1                     clock
// - reset_n             in   1                     asynchronous, active-low reset
// - sync_reset          in   1                     synchronous reset; same effect as reset_n
// - mem_cs              in   NUM_PORTS             per-port 1-cycle request pulse
// - mem_read0_write1    in   NUM_PORTS             per-port direction, sampled with mem_cs
// - mem_addr            in   NUM_PORTS*ADDR_BITS   word address, sampled with mem_cs
// - mem_byteenable      in   NUM_PORTS*XLEN/8      byte enables (1=active), sampled with mem_cs
// - mem_write_data      in   NUM_PORTS*XLEN        write data, sampled with mem_cs
// - mem_ack             out  NUM_PORTS             1-cycle completion pulse, one-hot
// - mem_read_data       out  XLEN                  read word; valid while mem_ack set
// - av_address          out  ADDR_BITS+log2(RATIO) Avalon address in AV_WIDTH units = {addr, beat}
// - av_byteenable_n     out  AV_WIDTH/8            byte enables, active low
// - av_chipselect       out  1                     active during beat issue
// - av_read_n           out  1                     active-low read strobe
// - av_write_n          out  1                     active-low write strobe
// - av_writedata        out  AV_WIDTH              write beat
// - av_readdata         in   AV_WIDTH              read beat
// - av_readdatavalid    in   1                     read beat valid
// - av_waitrequest      in   1                     slave stall
// - protocol_err        out  1                     sticky: readdatavalid seen with no read outstanding
// BEHAVIOUR
// - Reset (either source): all outputs 0 except av_read_n=1, av_write_n=1, av_byteenable_n=all 1s.
//   Pending flags clear, FSM goes to IDLE, RR pointer goes to port 0. In-flight read beats are discarded.
// - Request latching: mem_cs[p] pulse latches the request into a per-port pending register.
//   Simultaneous pulses on several ports are all latched. A port issues no new mem_cs until its ack; a violation overwrites the pending request.
// - FSM states: IDLE -> ISSUE -> (read) COLLECT / (write) DONE -> IDLE.
// - IDLE: if any pending, grant the round-robin winner (search starts at last grant + 1) and load beat counter = 0.
//   For writes, first skip all-zero-enable beats. If every beat is skipped, go to DONE.
// - ISSUE: drive beat b, with av_address={addr,b}, data/enables slice b (beat 0 = LS bits = lowest address).
//   Hold all Avalon outputs stable while av_waitrequest=1. Advance b when waitrequest=0.
//   For writes, skip zero-enable beats. Reads issue all RATIO beats, enables all active.
//   After the last beat accepted: read -> COLLECT, write -> DONE.
// - COLLECT: each av_readdatavalid stores av_readdata into slice rcnt, then rcnt++.
//   Beats can return during ISSUE and are counted there too. When rcnt reaches RATIO -> DONE.
// - DONE: pulse mem_ack[grant] for 1 cycle, with mem_read_data valid (reads; 0 for writes). Clear pending[grant]. -> IDLE.
// - Latency, no stalls: write ack at grant+RATIO+1 cycles. Read ack 1 cycle after last readdatavalid.
// - A new mem_cs on the port being acked, in its DONE cycle, is latched. It is not lost.
// - av_readdatavalid while no read is outstanding sets protocol_err, and the data is dropped.
// - RATIO=1 degenerates to a pass-through with arbitration. Address wrap is not checked.
// STRUCTURE
// - Package reindeer_mem_bridge_pkg holds:
//   - typedef enum {IDLE, ISSUE, COLLECT, DONE} bridge_state_t
//   - a function for the next non-zero beat index
// - Sub-module rr_arbiter #(N): inputs req[N], advance; output one-hot grant[N]. The pointer updates on advance.
// - Top level holds the pending registers, FSM, beat/rcnt counters and the read assembly register.
// TESTING
// - T1: RATIO=2. Port0 write addr 0x10, data 0xA5A5_1234, be 4'hF -> av beats (0x20,0x1234),(0x21,0xA5A5); ack at +3 cycles.
// - T2: Port0 read addr 0x10, slave returns 0x1234 then 0xA5A5, 2 and 5 cycles later -> mem_read_data 0xA5A5_1234; ack 1 cycle after the 2nd beat.
// - T3: Write be 4'b1100 -> only beat 1 issued (addr 0x21, byteenable_n 2'b00). Write be 4'b0000 -> no beats; ack in 2 cycles.
// - T4: Port0 and port1 both pulse mem_cs in the same cycle, 3 rounds -> grant order 0,1,0,1,0,1; no request lost.
// - T5: av_waitrequest held 4 cycles on beat 0 -> outputs stable throughout; beat 1 only after release; ack delayed 4.
// - T6: reset_n asserted mid-COLLECT -> outputs at reset values immediately; late readdatavalid after reset sets protocol_err; no mem_ack.

Source files
------------

// File: rtl/reindeer_mem_bridge_pkg.sv
// Shared types and helpers for the multi-port memory to Avalon-MM bridge.
package reindeer_mem_bridge_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DONE} bridge_state_t;

  localparam int unsigned MAX_RATIO = 8;
  localparam int unsigned MAX_BE    = 64;

  // Lowest beat index >= from whose byte enables are not all zero; ratio if none.
  function automatic int unsigned next_nz_beat(input logic [MAX_BE-1:0] be,
                                               input int unsigned       bpb,
                                               input int unsigned       ratio,
                                               input int unsigned       from);
    logic [MAX_BE-1:0] mask;
    next_nz_beat = ratio;
    mask = (MAX_BE'(1) << bpb) - MAX_BE'(1);
    for (int unsigned i = MAX_RATIO; i > 0; i--) begin
      if ((i - 1) >= from && (i - 1) < ratio && ((be >> ((i - 1) * bpb)) & mask) != '0)
        next_nz_beat = i - 1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/mem_avalon_bridge_mp.sv
// N memory ports share one Avalon-MM slave; each XLEN access becomes RATIO narrow beats.
module mem_avalon_bridge_mp
  import reindeer_mem_bridge_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AV_WIDTH  = 16,
  parameter int unsigned ADDR_BITS = 21
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        sync_reset,
  input  logic [NUM_PORTS-1:0]                        mem_cs,
  input  logic [NUM_PORTS-1:0]                        mem_read0_write1,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]              mem_addr,
  input  logic [NUM_PORTS*XLEN/8-1:0]                 mem_byteenable,
  input  logic [NUM_PORTS*XLEN-1:0]                   mem_write_data,
  output logic [NUM_PORTS-1:0]                        mem_ack,
  output logic [XLEN-1:0]                             mem_read_data,
  output logic [ADDR_BITS+$clog2(XLEN/AV_WIDTH)-1:0]  av_address,
  output logic [AV_WIDTH/8-1:0]                       av_byteenable_n,
  output logic                                        av_chipselect,
  output logic                                        av_read_n,
  output logic                                        av_write_n,
  output logic [AV_WIDTH-1:0]                         av_writedata,
  input  logic [AV_WIDTH-1:0]                         av_readdata,
  input  logic                                        av_readdatavalid,
  input  logic                                        av_waitrequest,
  output logic                                        protocol_err
);

  localparam int unsigned RATIO = XLEN / AV_WIDTH;
  localparam int unsigned LR    = $clog2(RATIO);
  localparam int unsigned CW    = LR + 1;
  localparam int unsigned BPB   = AV_WIDTH / 8;
  localparam int unsigned BEB   = XLEN / 8;
  localparam int unsigned PIDX  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned AW    = ADDR_BITS + LR;

  bridge_state_t        state;
  logic [NUM_PORTS-1:0] pend_v, pend_wr, grant;
  logic [ADDR_BITS-1:0] pend_addr [NUM_PORTS];
  logic [BEB-1:0]       pend_be   [NUM_PORTS];
  logic [XLEN-1:0]      pend_wd   [NUM_PORTS];

  logic [PIDX-1:0]      cur_port, gidx;
  logic                 cur_wr;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [BEB-1:0]       cur_be;
  logic [XLEN-1:0]      cur_wd;
  logic [CW-1:0]        beat, rcnt, rcnt_nxt, first_beat, next_beat, sel_beat;
  logic [XLEN-1:0]      rdata;
  logic                 rd_outstanding, advance;

  logic                 src_wr;
  logic [ADDR_BITS-1:0] src_addr;
  logic [BEB-1:0]       src_be;
  logic [XLEN-1:0]      src_wd;
  logic [AW-1:0]        issue_addr;
  logic [BPB-1:0]       issue_be_n;
  logic [AV_WIDTH-1:0]  issue_wd;

  assign advance       = (state == IDLE) && (|pend_v);
  assign mem_read_data = rdata;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (sync_reset),
    .req     (pend_v),
    .advance (advance),
    .grant   (grant)
  );

  // A fresh mem_cs wins over the DONE clear, so a re-request during ack is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v  <= '0;
      pend_wr <= '0;
    end else if (sync_reset) begin
      pend_v  <= '0;
      pend_wr <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (mem_cs[p]) begin
          pend_v[p]  <= 1'b1;
          pend_wr[p] <= mem_read0_write1[p];
        end else if (state == DONE && cur_port == PIDX'(p)) begin
          pend_v[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (mem_cs[p]) begin
        pend_addr[p] <= mem_addr[p*ADDR_BITS +: ADDR_BITS];
        pend_be[p]   <= mem_byteenable[p*BEB +: BEB];
        pend_wd[p]   <= mem_write_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) gidx = PIDX'(k);
    end
    rd_outstanding = !cur_wr && ((state == ISSUE && rcnt < beat) || state == COLLECT);
    rcnt_nxt   = rcnt + CW'(av_readdatavalid && rd_outstanding);
    first_beat = pend_wr[gidx] ? CW'(next_nz_beat(MAX_BE'(pend_be[gidx]), BPB, RATIO, 0)) : '0;
    next_beat  = cur_wr ? CW'(next_nz_beat(MAX_BE'(cur_be), BPB, RATIO, 32'(beat) + 32'd1))
                        : beat + CW'(1);
    if (state == IDLE) begin
      src_wr   = pend_wr[gidx];
      src_addr = pend_addr[gidx];
      src_be   = pend_be[gidx];
      src_wd   = pend_wd[gidx];
      sel_beat = first_beat;
    end else begin
      src_wr   = cur_wr;
      src_addr = cur_addr;
      src_be   = cur_be;
      src_wd   = cur_wd;
      sel_beat = next_beat;
    end
    issue_addr = (AW'(src_addr) << LR) | AW'(sel_beat);
    issue_be_n = src_wr ? ~BPB'(src_be >> (32'(sel_beat) * BPB)) : '0;
    issue_wd   = src_wr ? AV_WIDTH'(src_wd >> (32'(sel_beat) * AV_WIDTH)) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cur_port <= '0; cur_wr <= 1'b0; cur_addr <= '0; cur_be <= '0; cur_wd <= '0;
      beat <= '0; rcnt <= '0; rdata <= '0; mem_ack <= '0; protocol_err <= 1'b0;
      av_chipselect <= 1'b0; av_read_n <= 1'b1; av_write_n <= 1'b1;
      av_address <= '0; av_byteenable_n <= '1; av_writedata <= '0;
    end else if (sync_reset) begin
      state <= IDLE;
      cur_port <= '0; cur_wr <= 1'b0; cur_addr <= '0; cur_be <= '0; cur_wd <= '0;
      beat <= '0; rcnt <= '0; rdata <= '0; mem_ack <= '0; protocol_err <= 1'b0;
      av_chipselect <= 1'b0; av_read_n <= 1'b1; av_write_n <= 1'b1;
      av_address <= '0; av_byteenable_n <= '1; av_writedata <= '0;
    end else begin
      mem_ack <= '0;
      // Read beats may return while later beats are still being issued.
      if (av_readdatavalid) begin
        if (rd_outstanding) begin
          rdata[rcnt*AV_WIDTH +: AV_WIDTH] <= av_readdata;
          rcnt <= rcnt_nxt;
        end else begin
          protocol_err <= 1'b1;
        end
      end
      unique case (state)
        IDLE: if (|pend_v) begin
          cur_port <= gidx;
          cur_wr   <= src_wr;
          cur_addr <= src_addr;
          cur_be   <= src_be;
          cur_wd   <= src_wd;
          beat     <= first_beat;
          rcnt     <= '0;
          rdata    <= '0;
          if (first_beat == CW'(RATIO)) begin
            state         <= DONE;
            mem_ack[gidx] <= 1'b1;
          end else begin
            state           <= ISSUE;
            av_chipselect   <= 1'b1;
            av_read_n       <= src_wr;
            av_write_n      <= !src_wr;
            av_address      <= issue_addr;
            av_byteenable_n <= issue_be_n;
            av_writedata    <= issue_wd;
          end
        end
        ISSUE: if (!av_waitrequest) begin
          beat <= next_beat;
          if (next_beat == CW'(RATIO)) begin
            av_chipselect   <= 1'b0;
            av_read_n       <= 1'b1;
            av_write_n      <= 1'b1;
            av_address      <= '0;
            av_byteenable_n <= '1;
            av_writedata    <= '0;
            if (cur_wr || rcnt_nxt == CW'(RATIO)) begin
              state             <= DONE;
              mem_ack[cur_port] <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end else begin
            av_address      <= issue_addr;
            av_byteenable_n <= issue_be_n;
            av_writedata    <= issue_wd;
          end
        end
        COLLECT: if (rcnt_nxt == CW'(RATIO)) begin
          state             <= DONE;
          mem_ack[cur_port] <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_avalon_bridge_mp.sv
// Scoreboard bench for mem_avalon_bridge_mp (2 ports, 32-bit requesters, 16-bit Avalon).
module tb_mem_avalon_bridge_mp;

  logic        clk = 1'b0;
  logic        reset_n, sync_reset;
  logic [1:0]  mem_cs, mem_read0_write1;
  logic [41:0] mem_addr;
  logic [7:0]  mem_byteenable;
  logic [63:0] mem_write_data;
  logic [1:0]  mem_ack;
  logic [31:0] mem_read_data;
  logic [21:0] av_address;
  logic [1:0]  av_byteenable_n;
  logic        av_chipselect, av_read_n, av_write_n;
  logic [15:0] av_writedata, av_readdata;
  logic        av_readdatavalid, av_waitrequest, protocol_err;

  mem_avalon_bridge_mp #(.NUM_PORTS(2), .XLEN(32), .AV_WIDTH(16), .ADDR_BITS(21)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .mem_cs(mem_cs), .mem_read0_write1(mem_read0_write1), .mem_addr(mem_addr),
    .mem_byteenable(mem_byteenable), .mem_write_data(mem_write_data),
    .mem_ack(mem_ack), .mem_read_data(mem_read_data),
    .av_address(av_address), .av_byteenable_n(av_byteenable_n), .av_chipselect(av_chipselect),
    .av_read_n(av_read_n), .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .av_waitrequest(av_waitrequest), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [21:0] addr; logic [1:0] be_n; bit wr; logic [15:0] data; int cyc; } beat_t;
  typedef struct { logic [1:0] ack; logic [31:0] data; int cyc; } ack_t;

  beat_t beat_q[$];
  ack_t  ack_q[$];
  beat_t mb;
  ack_t  ma;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  int    k;

  localparam logic [77:0] RST_VEC = {1'b0, 1'b1, 1'b1, 2'b11, 22'd0, 16'd0, 2'b00, 32'd0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [77:0] outs();
    return {av_chipselect, av_read_n, av_write_n, av_byteenable_n, av_address,
            av_writedata, mem_ack, mem_read_data, protocol_err};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic exp_beat(input logic [21:0] a, input logic [1:0] ben, input bit wr,
                          input logic [15:0] d, input int c);
    beat_t b;
    b.addr = a; b.be_n = ben; b.wr = wr; b.data = d; b.cyc = c;
    beat_q.push_back(b);
  endtask

  task automatic exp_ack(input logic [1:0] ack, input logic [31:0] d, input int c);
    ack_t a;
    a.ack = ack; a.data = d; a.cyc = c;
    ack_q.push_back(a);
  endtask

  task automatic set_req(input int p, input bit wr, input logic [20:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    mem_cs[p] = 1'b1;
    mem_read0_write1[p] = wr;
    mem_addr[p*21 +: 21] = a;
    mem_byteenable[p*4 +: 4] = be;
    mem_write_data[p*32 +: 32] = wd;
  endtask

  task automatic pulse();
    tick(1);
    mem_cs = '0;
  endtask

  task automatic rdv(input logic [15:0] d);
    av_readdatavalid = 1'b1;
    av_readdata = d;
    tick(1);
    av_readdatavalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((ack_q.size() != 0 || beat_q.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, 128'(ack_q.size() + beat_q.size()), 128'd0);
    ack_q.delete();
    beat_q.delete();
    tick(2);
  endtask

  // Monitor: every accepted beat and every ack is matched against the queues.
  always @(negedge clk) begin
    if (reset_n && av_chipselect && !av_waitrequest) begin
      if (beat_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat: got addr 0x%0h, required no Avalon beat", av_address);
      end else begin
        mb = beat_q.pop_front();
        chk("beat_addr", 128'(av_address), 128'(mb.addr));
        chk("beat_be_n", 128'(av_byteenable_n), 128'(mb.be_n));
        chk("beat_dir", 128'({av_write_n, av_read_n}), mb.wr ? 128'(2'b01) : 128'(2'b10));
        if (mb.wr) chk("beat_wdata", 128'(av_writedata), 128'(mb.data));
        if (mb.cyc >= 0) chk("beat_cycle", 128'(cyc), 128'(mb.cyc));
      end
    end
    if (mem_ack != 2'b00) begin
      if (ack_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ack: got mem_ack 0x%0h, required none", mem_ack);
      end else begin
        ma = ack_q.pop_front();
        chk("ack_port", 128'(mem_ack), 128'(ma.ack));
        chk("ack_rdata", 128'(mem_read_data), 128'(ma.data));
        if (ma.cyc >= 0) chk("ack_cycle", 128'(cyc), 128'(ma.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0;
    mem_cs = '0; mem_read0_write1 = '0; mem_addr = '0; mem_byteenable = '0; mem_write_data = '0;
    av_readdata = '0; av_readdatavalid = 1'b0; av_waitrequest = 1'b0;
    tick(3);
    chk("reset_outputs", 128'(outs()), 128'(RST_VEC));
    reset_n = 1'b1;
    tick(2);
    chk("post_reset_outputs", 128'(outs()), 128'(RST_VEC));

    // T1: full write, two beats, LS half first
    k = cyc;
    exp_beat(22'h20, 2'b00, 1, 16'h1234, k + 2);
    exp_beat(22'h21, 2'b00, 1, 16'hA5A5, k + 3);
    exp_ack(2'b01, 32'h0, k + 4);
    set_req(0, 1, 21'h10, 4'hF, 32'hA5A5_1234); pulse();
    drain("t1_drain");

    // T2: read, beats return 2 and 5 cycles after the first issue cycle
    k = cyc;
    exp_beat(22'h20, 2'b00, 0, 16'h0, k + 2);
    exp_beat(22'h21, 2'b00, 0, 16'h0, k + 3);
    exp_ack(2'b01, 32'hA5A5_1234, k + 8);
    set_req(0, 0, 21'h10, 4'hF, 32'h0); pulse();
    wait_until(k + 4); rdv(16'h1234);
    wait_until(k + 7); rdv(16'hA5A5);
    drain("t2_drain");

    // T2b: port1 read at top address, first beat returns during issue
    k = cyc;
    exp_beat(22'h3FFFFE, 2'b00, 0, 16'h0, k + 2);
    exp_beat(22'h3FFFFF, 2'b00, 0, 16'h0, k + 3);
    exp_ack(2'b10, 32'hCAFE_BEEF, k + 5);
    set_req(1, 0, 21'h1FFFFF, 4'hF, 32'h0); pulse();
    wait_until(k + 3); rdv(16'hBEEF); rdv(16'hCAFE);
    drain("t2b_drain");

    // T3: partial enables; all-zero write completes without beats
    k = cyc;
    exp_beat(22'h61, 2'b00, 1, 16'hDEAD, k + 2);
    exp_ack(2'b01, 32'h0, k + 3);
    set_req(0, 1, 21'h30, 4'b1100, 32'hDEAD_BEEF); pulse();
    drain("t3a_drain");
    k = cyc;
    exp_ack(2'b01, 32'h0, k + 2);
    set_req(0, 1, 21'h31, 4'b0000, 32'hFFFF_FFFF); pulse();
    drain("t3b_drain");
    k = cyc;
    exp_beat(22'h64, 2'b01, 1, 16'h5678, k + 2);
    exp_beat(22'h65, 2'b10, 1, 16'h1234, k + 3);
    exp_ack(2'b01, 32'h0, k + 4);
    set_req(0, 1, 21'h32, 4'b0110, 32'h1234_5678); pulse();
    drain("t3c_drain");

    // T5: waitrequest held for 4 cycles on beat 0
    k = cyc;
    av_waitrequest = 1'b1;
    exp_beat(22'h0E, 2'b00, 1, 16'hF00D, k + 6);
    exp_beat(22'h0F, 2'b00, 1, 16'h0BAD, k + 7);
    exp_ack(2'b10, 32'h0, k + 8);
    set_req(1, 1, 21'h7, 4'hF, 32'h0BAD_F00D); pulse();
    wait_until(k + 2);
    for (int i = 0; i < 4; i++) begin
      chk("wait_hold", 128'({av_chipselect, av_write_n, av_read_n, av_byteenable_n, av_address, av_writedata}),
          128'({1'b1, 1'b0, 1'b1, 2'b00, 22'h0E, 16'hF00D}));
      if (i < 3) tick(1);
    end
    tick(1);
    av_waitrequest = 1'b0;
    drain("t5_drain");

    // T7: re-request issued in the DONE cycle of the same port is kept
    k = cyc;
    exp_beat(22'h80, 2'b00, 1, 16'h2222, k + 2);
    exp_beat(22'h81, 2'b00, 1, 16'h1111, k + 3);
    exp_ack(2'b01, 32'h0, k + 4);
    exp_beat(22'h82, 2'b00, 1, 16'h4444, k + 6);
    exp_beat(22'h83, 2'b00, 1, 16'h3333, k + 7);
    exp_ack(2'b01, 32'h0, k + 8);
    set_req(0, 1, 21'h40, 4'hF, 32'h1111_2222); pulse();
    wait_until(k + 4);
    set_req(0, 1, 21'h41, 4'hF, 32'h3333_4444); pulse();
    drain("t7_drain");

    // T6: async reset in COLLECT, then a stray readdatavalid
    k = cyc;
    exp_beat(22'h0A, 2'b00, 0, 16'h0, k + 2);
    exp_beat(22'h0B, 2'b00, 0, 16'h0, k + 3);
    set_req(0, 0, 21'h5, 4'hF, 32'h0); pulse();
    wait_until(k + 4); rdv(16'h7777);
    reset_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 128'(outs()), 128'(RST_VEC));
    tick(2);
    reset_n = 1'b1;
    tick(1);
    rdv(16'h9999);
    chk("t6_protocol_err", 128'(protocol_err), 128'd1);
    chk("t6_rdata_dropped", 128'(mem_read_data), 128'd0);
    sync_reset = 1'b1;
    tick(1);
    sync_reset = 1'b0;
    chk("sync_reset_clears_err", 128'(protocol_err), 128'd0);
    drain("t6_drain");

    // T4: both ports request together, three rounds, alternating grants
    for (int r = 0; r < 3; r++) begin
      logic [31:0] wd0, wd1;
      wd0 = 32'hA000_0000 | 32'(r);
      wd1 = 32'hB000_0000 | 32'(r);
      k = cyc;
      exp_beat(22'(32'h200 + 2 * r), 2'b00, 1, wd0[15:0], k + 2);
      exp_beat(22'(32'h201 + 2 * r), 2'b00, 1, wd0[31:16], k + 3);
      exp_ack(2'b01, 32'h0, k + 4);
      exp_beat(22'(32'h400 + 2 * r), 2'b00, 1, wd1[15:0], k + 6);
      exp_beat(22'(32'h401 + 2 * r), 2'b00, 1, wd1[31:16], k + 7);
      exp_ack(2'b10, 32'h0, k + 8);
      set_req(0, 1, 21'(32'h100 + r), 4'hF, wd0);
      set_req(1, 1, 21'(32'h200 + r), 4'hF, wd1);
      pulse();
      drain("t4_drain");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
